prog_rom_sync: RTL and testbench
================================

Name: prog_rom_sync

Overview:
Parametrised synchronous program ROM for the multi-cycle MIPS32 core. It replaces the combinational ROM with a registered read pipeline, a req/ready/rvalid handshake, alignment and range checking, and a word-write program port for boot-time loading. It sits between the control unit's instruction fetch and the shared tristate instruction bus.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 9, word-index width; byte address is ADDR_W+2 bits
DEPTH, 512, number of implemented words (must be <= 2**ADDR_W)
LATENCY, 1, read latency in cycles from accept to rvalid; legal values are 1 or 2
FILL_WORD, 32'h0000_0000, word returned on error (the MIPS NOP, sll r0,r0,0)

Ports:
clk  in  1  rising-edge clock
nrst  in  1  reset: synchronous, active-low
nce  in  1  chip enable, active-low; gates both req acceptance and bus drive
req  in  1  read request; accepted only when req=1, ready=1, nce=0 and prog_en=0
addr  in  ADDR_W+2  byte address; bits [1:0] must be 0
ready  out  1  block can accept a request this cycle
rvalid  out  1  single-cycle pulse when rdata/d_out hold the requested word
rdata  out  DATA_W  registered read data
err  out  1  asserted with rvalid when the completed read was misaligned or out of range
err_sticky  out  1  set by any err; cleared only by reset
d_out  inout  DATA_W  tristate bus; carries rdata while rvalid=1 and nce=0, else high-Z
prog_en  in  1  program mode; blocks reads
prog_we  in  1  write strobe, honoured only while prog_en=1
prog_addr  in  ADDR_W  word index for a program write
prog_wdata  in  DATA_W  word to store
rd_count  out  16  count of completed reads, saturating at 16'hFFFF

Behaviour:
- Reset is synchronous on nrst=0 at a clk edge. It sets: state=IDLE, ready=1, rvalid=0, err=0, err_sticky=0, rdata=0, rd_count=0, and clears all pipeline stages. Memory contents are NOT altered by reset.
- States:
  - IDLE: ready=1. An accepted request goes to BUSY.
  - BUSY: ready=0. Counts LATENCY-1 cycles after accept, then emits the result.
  - PROG: entered whenever prog_en=1; ready=0. Returns to IDLE the cycle after prog_en falls.
- Accept in cycle T: addr is captured at T; rvalid=1 during cycle T+LATENCY.
  - With LATENCY=1, BUSY lasts 0 cycles and the block returns straight to IDLE.
  - ready is high in the rvalid cycle, so a back-to-back accept is allowed there. Sustained throughput is one read per LATENCY cycles.
- Word index = addr[ADDR_W+1:2].
  - Misaligned (addr[1:0]!=0) or index >= DEPTH: rdata=FILL_WORD, err=1 in the rvalid cycle, and err_sticky is set.
  - Both conditions together still give a single err.
- rdata holds its value until the next rvalid. err is a pulse that accompanies rvalid only.
- rd_count increments on every rvalid, including errored reads, and saturates at 16'hFFFF with no wrap.
- req with nce=1 or ready=0 is ignored, not queued. The requester must hold req until it is accepted.
- prog_en=1 while a read is in flight:
  - The in-flight read completes normally with its rvalid.
  - The state then enters PROG, and no new accepts occur.
  - prog_en has priority over a simultaneous req.
- Program write: at the clk edge with prog_en=1 and prog_we=1, mem[prog_addr] <= prog_wdata.
  - prog_addr >= DEPTH: the write is dropped and err_sticky is set.
  - prog_we while prog_en=0 is ignored.
- Read-after-write: a read accepted in the cycle after a write to the same index returns the new word.
- nce rising while rvalid=1 puts d_out at high-Z immediately. rvalid and rdata are unaffected.
- Reset mid-read: the pending result is discarded, with no rvalid in the following cycles.
- Parameter check: LATENCY outside {1,2} or DEPTH > 2**ADDR_W is a fatal elaboration error.

Test Plan:
1. Program, then read back. Load mem[0]=32'h2001_0008, mem[1]=32'h0001_0A00 via the prog port, drop prog_en, then read addr 0x000 and 0x004 with LATENCY=1 -> rvalid at T+1 each, rdata 32'h2001_0008 then 32'h0001_0A00, err=0, rd_count=2.
2. Back-to-back at LATENCY=2. Issue req at T with addr 0x000, and again at T+2 with addr 0x004 -> rvalid at T+2 and T+4, ready=0 at T+1 and T+3, d_out=rdata only during rvalid cycles.
3. Error reads. Read addr 0x002 (misaligned); set DEPTH=256 and read addr 0x400 (index 256) -> rdata=0, err=1 with each rvalid, err_sticky=1 after the first and until reset.
4. Mode interaction.
   - Assert prog_en in the cycle after accept (LATENCY=2) -> the read still completes at T+2, then ready stays 0.
   - req with prog_en=1 -> no accept.
   - Write index 600 with DEPTH=512 -> memory unchanged and err_sticky=1.
5. Reset and enable. Assert nrst=0 at T+1 of a LATENCY=2 read -> no rvalid at T+2, rd_count=0, ready=1 after release, previously programmed words still read correctly. Hold nce=1 with req=1 -> no accept, d_out=Z.
6. Saturation. Force 65537 reads -> rd_count holds 16'hFFFF.

Source files
------------

// File: rtl/prog_rom_sync.sv
// Synchronous program ROM for the multi-cycle MIPS32 core.
// Read latency of LATENCY cycles (1 or 2) from accept to the rvalid pulse, with a registered data path.
// No queueing: req is ignored unless ready, nce=0 and prog_en=0, and prog_en blocks new reads.
module prog_rom_sync #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 9,
   parameter int                DEPTH     = 512,
   parameter int                LATENCY   = 1,
   parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              nce,
   input  logic              req,
   input  logic [ADDR_W+1:0] addr,
   output logic              ready,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              err_sticky,
   inout  wire  [DATA_W-1:0] d_out,
   input  logic              prog_en,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic [15:0]       rd_count
);

   // Bad parameter combinations stop elaboration rather than building a broken ROM.
   if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $fatal(1, "prog_rom_sync: LATENCY must be 1 or 2");
   end
   if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $fatal(1, "prog_rom_sync: DEPTH exceeds 2**ADDR_W");
   end

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH always fits in ADDR_W+1 bits, so range checks are done at that width.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_PROG = 2'd2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              accept;
   logic [ADDR_W-1:0] a_idx;
   logic              a_bad;
   logic [ADDR_W-1:0] s_idx;
   logic              s_bad;
   logic              rd_fire;
   logic [ADDR_W-1:0] rd_idx;
   logic              rd_bad;
   logic              pw_in_range;
   logic              pw_ok;
   logic              pw_bad;

   assign ready  = (state == S_IDLE);
   // prog_en wins over a simultaneous req.
   assign accept = req && ready && !nce && !prog_en;

   // Drive the shared bus only while a result is presented and the chip is enabled.
   assign d_out = (rvalid && !nce) ? rdata : {DATA_W{1'bz}};

   // Decode the request address: word index plus misalignment / range error.
   always_comb begin
      a_idx = addr[ADDR_W+1:2];
      a_bad = (addr[1:0] != 2'b00) || ({1'b0, a_idx} >= DEPTH_L);
   end

   // Choose where the memory read is launched: at accept for LATENCY=1, from the capture stage otherwise.
   always_comb begin
      if (LATENCY == 1) begin
         rd_fire = accept;
         rd_idx  = a_idx;
         rd_bad  = a_bad;
      end else begin
         rd_fire = (state == S_BUSY);
         rd_idx  = s_idx;
         rd_bad  = s_bad;
      end
   end

   // Program-port write qualification; out-of-range writes are dropped and flagged.
   always_comb begin
      pw_in_range = ({1'b0, prog_addr} < DEPTH_L);
      pw_ok       = prog_en && prog_we && pw_in_range;
      pw_bad      = prog_en && prog_we && !pw_in_range;
   end

   // Next-state logic; BUSY only exists for LATENCY=2 and always lasts exactly one cycle,
   // and an in-flight read finishes before PROG is entered.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (prog_en) begin
               state_nxt = S_PROG;
            end else if (accept && (LATENCY == 2)) begin
               state_nxt = S_BUSY;
            end
         end
         S_BUSY:  state_nxt = prog_en ? S_PROG : S_IDLE;
         S_PROG:  state_nxt = prog_en ? S_PROG : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory array: written only through the program port, never touched by reset.
   always_ff @(posedge clk) begin
      if (pw_ok) begin
         mem[prog_addr[MEM_AW-1:0]] <= prog_wdata;
      end
   end

   // Control, capture stage, registered read data, error flags and read counter.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= S_IDLE;
         s_idx      <= '0;
         s_bad      <= 1'b0;
         rvalid     <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         rdata      <= '0;
         rd_count   <= '0;
      end else begin
         state  <= state_nxt;
         rvalid <= rd_fire;
         err    <= rd_fire && rd_bad;
         if (accept) begin
            s_idx <= a_idx;
            s_bad <= a_bad;
         end
         if (rd_fire) begin
            rdata <= rd_bad ? FILL_WORD : mem[rd_idx[MEM_AW-1:0]];
            if (rd_count != 16'hFFFF) begin
               rd_count <= rd_count + 16'd1;
            end
         end
         if ((rd_fire && rd_bad) || pw_bad) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prog_rom_sync.sv
// Bench for prog_rom_sync: two instances (LATENCY=1/DEPTH=512 and LATENCY=2/DEPTH=256) share stimulus.
// Every cycle both are compared against a timestamp-based reference model.
// Directed table rows and hand sequences add fixed expected values.
module tb_prog_rom_sync;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          nrst, nce, req, prog_en, prog_we;
   logic [AW+1:0] addr;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_wdata;

   logic        o_rdy [2];
   logic        o_rv  [2];
   logic        o_err [2];
   logic        o_st  [2];
   logic [31:0] o_rd  [2];
   logic [15:0] o_cnt [2];
   tri1  [31:0] dbus0;
   tri1  [31:0] dbus1;

   always #5 clk = ~clk;

   prog_rom_sync #(.DATA_W(32), .ADDR_W(AW), .DEPTH(512), .LATENCY(1), .FILL_WORD(32'h0)) u1 (
      .clk(clk), .nrst(nrst), .nce(nce), .req(req), .addr(addr),
      .ready(o_rdy[0]), .rvalid(o_rv[0]), .rdata(o_rd[0]), .err(o_err[0]), .err_sticky(o_st[0]),
      .d_out(dbus0), .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .rd_count(o_cnt[0]));

   prog_rom_sync #(.DATA_W(32), .ADDR_W(AW), .DEPTH(256), .LATENCY(2), .FILL_WORD(32'h0)) u2 (
      .clk(clk), .nrst(nrst), .nce(nce), .req(req), .addr(addr),
      .ready(o_rdy[1]), .rvalid(o_rv[1]), .rdata(o_rd[1]), .err(o_err[1]), .err_sticky(o_st[1]),
      .d_out(dbus1), .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .rd_count(o_cnt[1]));

   // Reference model state: memory image, one pending result with its due cycle, visible outputs.
   int unsigned cyc;
   logic [31:0] mmem [2][512];
   bit          ppe [2];
   int unsigned free_at [2];
   bit          pv [2];
   int unsigned pdue [2];
   logic [31:0] pdat [2];
   bit          perr [2];
   bit          m_rv [2];
   bit          m_err [2];
   bit          m_st [2];
   logic [31:0] m_rd [2];
   logic [15:0] m_cnt [2];

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      bit pe; bit we; logic [AW-1:0] pa; logic [31:0] wd;
      bit nce; bit req; logic [AW+1:0] addr;
      bit rv; logic [31:0] rd; bit er; bit st; logic [15:0] cnt;
   } vec_t;
   vec_t tbl [12];

   function automatic int ml(int k); return k + 1; endfunction
   function automatic int md(int k); return (k == 0) ? 512 : 256; endfunction
   function automatic logic [31:0] pat(int i);
      return 32'h1000_0000 | (32'(i) << 8) | 32'(i);
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d cyc=%0d: got %h, want %h", nm, k, cyc, act, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs held during the ending cycle.
   task automatic model_step();
      int idx;
      bit bad;
      for (int k = 0; k < 2; k++) begin
         if (!nrst) begin
            pv[k] = 0; free_at[k] = 0; ppe[k] = 0;
            m_rv[k] = 0; m_err[k] = 0; m_st[k] = 0; m_rd[k] = '0; m_cnt[k] = '0;
         end else begin
            if (req && !nce && !prog_en && !ppe[k] && cyc >= free_at[k]) begin
               idx        = int'(addr >> 2);
               bad        = (addr[1:0] != 2'b00) || (idx >= md(k));
               pv[k]      = 1;
               pdue[k]    = cyc + ml(k);
               free_at[k] = cyc + ml(k);
               perr[k]    = bad;
               pdat[k]    = bad ? 32'h0 : mmem[k][idx];
            end
            if (prog_en && prog_we) begin
               if (int'(prog_addr) < md(k)) mmem[k][prog_addr] = prog_wdata;
               else m_st[k] = 1;
            end
            m_rv[k]  = 0;
            m_err[k] = 0;
            if (pv[k] && pdue[k] == cyc + 1) begin
               m_rv[k]  = 1;
               m_rd[k]  = pdat[k];
               m_err[k] = perr[k];
               if (perr[k]) m_st[k] = 1;
               if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
               pv[k] = 0;
            end
            ppe[k] = prog_en;
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      logic [31:0] dexp;
      logic [31:0] dact;
      for (int k = 0; k < 2; k++) begin
         chk("ready",  k, o_rdy[k], (!ppe[k] && cyc >= free_at[k]) ? 32'd1 : 32'd0);
         chk("rvalid", k, o_rv[k],  m_rv[k]);
         chk("rdata",  k, o_rd[k],  m_rd[k]);
         chk("err",    k, o_err[k], m_err[k]);
         chk("sticky", k, o_st[k],  m_st[k]);
         chk("count",  k, o_cnt[k], m_cnt[k]);
         dexp = (m_rv[k] && !nce) ? m_rd[k] : 32'hFFFF_FFFF;
         dact = (k == 0) ? dbus0 : dbus1;
         chk("d_out",  k, dact, dexp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      int r;
      cyc = 0;
      nrst = 0; nce = 0; req = 0; addr = '0;
      prog_en = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
      tick(); tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready",  k, o_rdy[k], 32'd1);
         chk("rst_rvalid", k, o_rv[k],  32'd0);
         chk("rst_rdata",  k, o_rd[k],  32'd0);
         chk("rst_sticky", k, o_st[k],  32'd0);
         chk("rst_count",  k, o_cnt[k], 32'd0);
      end

      // Preload every word with a known pattern, then reset (memory must survive).
      nrst = 1;
      for (int i = 0; i < 512; i++) begin
         prog_en = 1; prog_we = 1; prog_addr = AW'(i); prog_wdata = pat(i);
         tick();
      end
      prog_en = 0; prog_we = 0; nrst = 0;
      tick();
      nrst = 1;

      // Directed rows checked on the LATENCY=1 / DEPTH=512 instance.
      tbl[0]  = '{1'b1, 1'b1, 10'd0,   32'h2001_0008, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 10'd1,   32'h0001_0A00, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'h000, 1'b1, 32'h2001_0008,  1'b0, 1'b0, 16'd1};
      tbl[4]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'h004, 1'b1, 32'h0001_0A00,  1'b0, 1'b0, 16'd2};
      tbl[5]  = '{1'b1, 1'b1, 10'd600, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0001_0A00,  1'b0, 1'b1, 16'd2};
      tbl[6]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'h160, 1'b0, 32'h0001_0A00,  1'b0, 1'b1, 16'd2};
      tbl[7]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'h160, 1'b1, 32'h1000_5858,  1'b0, 1'b1, 16'd3};
      tbl[8]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'h002, 1'b1, 32'h0,          1'b1, 1'b1, 16'd4};
      tbl[9]  = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b1, 12'hFFF, 1'b1, 32'h0,          1'b1, 1'b1, 16'd5};
      tbl[10] = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b1, 1'b1, 12'h000, 1'b0, 32'h0,          1'b0, 1'b1, 16'd5};
      tbl[11] = '{1'b0, 1'b0, 10'd0,   32'h0,         1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b1, 16'd5};
      for (int i = 0; i < 12; i++) begin
         prog_en = tbl[i].pe; prog_we = tbl[i].we; prog_addr = tbl[i].pa; prog_wdata = tbl[i].wd;
         nce = tbl[i].nce; req = tbl[i].req; addr = tbl[i].addr;
         tick();
         chk("tbl_rvalid", 0, o_rv[0],  tbl[i].rv);
         chk("tbl_rdata",  0, o_rd[0],  tbl[i].rd);
         chk("tbl_err",    0, o_err[0], tbl[i].er);
         chk("tbl_sticky", 0, o_st[0],  tbl[i].st);
         chk("tbl_count",  0, o_cnt[0], tbl[i].cnt);
      end
      nce = 0; req = 0; prog_en = 0; prog_we = 0;

      // Back-to-back reads on the LATENCY=2 instance.
      nrst = 0; tick(); nrst = 1;
      req = 1; addr = 12'h000; tick();
      chk("b2b_ready_t1", 1, o_rdy[1], 32'd0);
      chk("b2b_rv_t1",    1, o_rv[1],  32'd0);
      chk("b2b_dout_t1",  1, dbus1,    32'hFFFF_FFFF);
      req = 0; tick();
      chk("b2b_rv_t2",    1, o_rv[1],  32'd1);
      chk("b2b_rd_t2",    1, o_rd[1],  32'h2001_0008);
      chk("b2b_ready_t2", 1, o_rdy[1], 32'd1);
      chk("b2b_dout_t2",  1, dbus1,    32'h2001_0008);
      req = 1; addr = 12'h004; tick();
      chk("b2b_ready_t3", 1, o_rdy[1], 32'd0);
      chk("b2b_rv_t3",    1, o_rv[1],  32'd0);
      req = 0; tick();
      chk("b2b_rv_t4",    1, o_rv[1],  32'd1);
      chk("b2b_rd_t4",    1, o_rd[1],  32'h0001_0A00);
      tick();

      // prog_en raised while a read is in flight.
      req = 1; addr = 12'h000; tick();
      req = 0; prog_en = 1; tick();
      chk("prg_rv_t2",    1, o_rv[1],  32'd1);
      chk("prg_rd_t2",    1, o_rd[1],  32'h2001_0008);
      chk("prg_ready_t2", 1, o_rdy[1], 32'd0);
      req = 1; addr = 12'h004; tick();
      chk("prg_noacc_rv", 1, o_rv[1],  32'd0);
      chk("prg_ready_t3", 1, o_rdy[1], 32'd0);
      prog_en = 0; req = 0; tick();
      chk("prg_exit_rdy", 1, o_rdy[1], 32'd1);
      tick(); tick();

      // Reset in the middle of a LATENCY=2 read.
      req = 1; addr = 12'h004; tick();
      nrst = 0; req = 0; tick();
      chk("rstmid_rv",    1, o_rv[1],  32'd0);
      chk("rstmid_cnt",   1, o_cnt[1], 32'd0);
      chk("rstmid_ready", 1, o_rdy[1], 32'd1);
      nrst = 1; tick();
      chk("rstmid_rv2",   1, o_rv[1],  32'd0);
      req = 1; addr = 12'h004; tick();
      req = 0; tick();
      chk("rstmid_keep",  1, o_rd[1],  32'h0001_0A00);

      // Error reads on the DEPTH=256 instance.
      chk("err_pre_st",   1, o_st[1],  32'd0);
      req = 1; addr = 12'h400; tick();
      req = 0; tick();
      chk("oor_rv",  1, o_rv[1],  32'd1);
      chk("oor_err", 1, o_err[1], 32'd1);
      chk("oor_rd",  1, o_rd[1],  32'd0);
      chk("oor_st",  1, o_st[1],  32'd1);
      req = 1; addr = 12'h002; tick();
      req = 0; tick();
      chk("mis_err", 1, o_err[1], 32'd1);
      req = 1; addr = 12'h008; tick();
      req = 0; tick();
      chk("ok_err",  1, o_err[1], 32'd0);
      chk("ok_st",   1, o_st[1],  32'd1);

      // Chip enable: no accept while nce=1, and the bus releases as soon as nce rises.
      nce = 1; req = 1; addr = 12'h000;
      tick(); tick(); tick();
      chk("nce_rv0",   0, o_rv[0], 32'd0);
      chk("nce_rv1",   1, o_rv[1], 32'd0);
      chk("nce_dout0", 0, dbus0,   32'hFFFF_FFFF);
      nce = 0; tick();
      req = 0; nce = 1; #1;
      chk("nce_rise_rv",   0, o_rv[0], 32'd1);
      chk("nce_rise_rd",   0, o_rd[0], 32'h2001_0008);
      chk("nce_rise_dout", 0, dbus0,   32'hFFFF_FFFF);
      tick();
      nce = 0; tick(); tick();

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         nrst = ($urandom_range(0, 199) != 0);
         nce  = ($urandom_range(0, 7) == 0);
         req  = ($urandom_range(0, 3) != 0);
         r    = $urandom_range(0, 15);
         if (r < 12)      addr = 12'($urandom_range(0, 383)) << 2;
         else if (r < 14) addr = 12'($urandom_range(0, 4095));
         else             addr = 12'($urandom_range(0, 1023)) << 2;
         if (prog_en) prog_en = ($urandom_range(0, 3) != 0);
         else         prog_en = ($urandom_range(0, 19) == 0);
         prog_we    = nrst && ($urandom_range(0, 1) == 1);
         prog_addr  = AW'($urandom_range(0, 1023));
         prog_wdata = $urandom;
         tick();
      end

      // Counter saturation: continuous single-cycle reads on the LATENCY=1 instance.
      nrst = 0; nce = 0; req = 0; prog_en = 0; prog_we = 0;
      tick();
      nrst = 1; req = 1; addr = 12'h008;
      for (int i = 0; i < 65540; i++) tick();
      chk("sat_count", 0, o_cnt[0], 32'h0000_FFFF);
      chk("sat_rv",    0, o_rv[0],  32'd1);
      req = 0; tick();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
